// File: rtl/reg_bank_pkg.sv
// reg_bank shared types and default sizes.
// Imported by the interface, the clear sequencer and the top.
package reg_bank_pkg;

    localparam int REG_W  = 8;
    localparam int REG_AW = 4;
    localparam int REG_FW = 3;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        DONE
    } clr_state_t;

endpackage

// File: rtl/reg_bank_if.sv
// reg_bank bus: write port, two read ports, flag load and bulk-clear control.
// The controller side uses master, the register bank uses slave.
interface reg_bank_if #(
    parameter int W  = reg_bank_pkg::REG_W,
    parameter int AW = reg_bank_pkg::REG_AW,
    parameter int FW = reg_bank_pkg::REG_FW
);

    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [W-1:0]  dat_in;
    logic [AW-1:0] rd_addr0;
    logic [AW-1:0] rd_addr1;
    logic [W-1:0]  datA_out;
    logic [W-1:0]  datB_out;
    logic          flag_en;
    logic [FW-1:0] alu_flags;
    logic [FW-1:0] alu_flag_ff;
    logic          clr_req;
    logic          busy;
    logic          clr_done;

    modport master (
        output wr_en, wr_addr, dat_in,
        output rd_addr0, rd_addr1,
        output flag_en, alu_flags, clr_req,
        input  datA_out, datB_out,
        input  alu_flag_ff, busy, clr_done
    );

    modport slave (
        input  wr_en, wr_addr, dat_in,
        input  rd_addr0, rd_addr1,
        input  flag_en, alu_flags, clr_req,
        output datA_out, datB_out,
        output alu_flag_ff, busy, clr_done
    );

endinterface

// File: rtl/reg_bank_clr_seq.sv
// Bulk-clear sequencer: sweeps ptr over every entry, one per cycle,
// then pulses clr_done for a single cycle before returning to IDLE.
module reg_bank_clr_seq
    import reg_bank_pkg::*;
#(
    parameter int AW = REG_AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr_req,
    output logic          busy,
    output logic          clr_done,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr
);

    localparam logic [AW-1:0] LAST = '1;

    clr_state_t    state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d = CLEAR;
                    ptr_d   = '0;
                end
            end
            CLEAR: begin
                ptr_d = ptr_q + AW'(1);
                if (ptr_q == LAST) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Outputs are registered off the next state so they align with it
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy     = busy_q;
    assign clr_done = done_q;
    assign clr_we   = (state_q == CLEAR);
    assign clr_addr = ptr_q;

endmodule

// File: rtl/reg_bank.sv
// 2**AW x W register bank: two async read ports, one write port, flags, bulk clear.
// Define REG_BANK_BYPASS_EN for same-cycle write-through forwarding on reads.
module reg_bank
    import reg_bank_pkg::*;
#(
    parameter int W  = REG_W,
    parameter int AW = REG_AW,
    parameter int FW = REG_FW
) (
    input logic       clk,
    input logic       reset,
    reg_bank_if.slave bus
);

    localparam int DEPTH = 2 ** AW;

    logic [W-1:0]  regs_q [DEPTH];
    logic [W-1:0]  regs_d [DEPTH];
    logic [FW-1:0] flags_q, flags_d;
    logic          busy;
    logic          clr_done;
    logic          clr_we;
    logic [AW-1:0] clr_addr;
    logic          wr_accept;
    logic [W-1:0]  rd_a;
    logic [W-1:0]  rd_b;

    reg_bank_clr_seq #(
        .AW(AW)
    ) u_clr_seq (
        .clk     (clk),
        .reset   (reset),
        .clr_req (bus.clr_req),
        .busy    (busy),
        .clr_done(clr_done),
        .clr_we  (clr_we),
        .clr_addr(clr_addr)
    );

    // Writes during a clear are dropped, never queued
    assign wr_accept = bus.wr_en && !busy && !reset;

    always_comb begin
        regs_d = regs_q;
        if (clr_we) begin
            regs_d[clr_addr] = '0;
        end else if (wr_accept) begin
            regs_d[bus.wr_addr] = bus.dat_in;
        end
        flags_d = bus.flag_en ? bus.alu_flags : flags_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            regs_q  <= '{default: '0};
            flags_q <= '0;
        end else begin
            regs_q  <= regs_d;
            flags_q <= flags_d;
        end
    end

    always_comb begin
        rd_a = regs_q[bus.rd_addr0];
        rd_b = regs_q[bus.rd_addr1];
`ifdef REG_BANK_BYPASS_EN
        if (wr_accept && bus.rd_addr0 == bus.wr_addr) rd_a = bus.dat_in;
        if (wr_accept && bus.rd_addr1 == bus.wr_addr) rd_b = bus.dat_in;
`endif
    end

    assign bus.datA_out    = rd_a;
    assign bus.datB_out    = rd_b;
    assign bus.alu_flag_ff = flags_q;
    assign bus.busy        = busy;
    assign bus.clr_done    = clr_done;

endmodule

// File: tb/tb_reg_bank.sv
// Directed self-checking bench for reg_bank (16 x 8, 3-bit flags).
// Expectations follow REG_BANK_BYPASS_EN when it is defined.
module tb_reg_bank;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    reg_bank_if #(.W(8), .AW(4), .FW(3)) bus ();

    reg_bank #(
        .W (8),
        .AW(4),
        .FW(3)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        #1;
        n_cmp++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy got %b exp 0", bus.busy);
        end
        n_cmp++;
        if (bus.clr_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_done got %b exp 0", bus.clr_done);
        end
        n_cmp++;
        if (bus.alu_flag_ff !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags got %b exp 000", bus.alu_flag_ff);
        end
        for (int i = 0; i < 16; i++) begin
            bus.rd_addr0 = 4'(i);
            #1;
            n_cmp++;
            if (bus.datA_out !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_r%0d got %h exp 00", i, bus.datA_out);
            end
        end
    endtask

    task automatic test_write_read();
        bus.wr_en   = 1'b1;
        bus.wr_addr = 4'd3;
        bus.dat_in  = 8'hA5;
        step();
        bus.wr_addr = 4'd15;
        bus.dat_in  = 8'h3C;
        step();
        bus.wr_en    = 1'b0;
        bus.rd_addr0 = 4'd3;
        bus.rd_addr1 = 4'd15;
        #1;
        n_cmp++;
        if (bus.datA_out !== 8'hA5) begin
            n_fail++;
            $display("FAIL wr_r3 got %h exp a5", bus.datA_out);
        end
        n_cmp++;
        if (bus.datB_out !== 8'h3C) begin
            n_fail++;
            $display("FAIL wr_r15 got %h exp 3c", bus.datB_out);
        end
        bus.rd_addr0 = 4'd5;
        bus.rd_addr1 = 4'd0;
        #1;
        n_cmp++;
        if (bus.datA_out !== 8'h00) begin
            n_fail++;
            $display("FAIL wr_r5 got %h exp 00", bus.datA_out);
        end
        n_cmp++;
        if (bus.datB_out !== 8'h00) begin
            n_fail++;
            $display("FAIL wr_r0 got %h exp 00", bus.datB_out);
        end
    endtask

    task automatic test_same_cycle();
        logic [7:0] exp_now;
`ifdef REG_BANK_BYPASS_EN
        exp_now = 8'h5A;
`else
        exp_now = 8'h00;
`endif
        bus.rd_addr0 = 4'd7;
        bus.rd_addr1 = 4'd3;
        bus.wr_en    = 1'b1;
        bus.wr_addr  = 4'd7;
        bus.dat_in   = 8'h5A;
        #1;
        n_cmp++;
        if (bus.datA_out !== exp_now) begin
            n_fail++;
            $display("FAIL same_cyc_r7 got %h exp %h", bus.datA_out, exp_now);
        end
        n_cmp++;
        if (bus.datB_out !== 8'hA5) begin
            n_fail++;
            $display("FAIL same_cyc_portb got %h exp a5", bus.datB_out);
        end
        step();
        bus.wr_en = 1'b0;
        #1;
        n_cmp++;
        if (bus.datA_out !== 8'h5A) begin
            n_fail++;
            $display("FAIL next_cyc_r7 got %h exp 5a", bus.datA_out);
        end
    endtask

    task automatic test_flags();
        bus.flag_en   = 1'b1;
        bus.alu_flags = 3'b101;
        step();
        n_cmp++;
        if (bus.alu_flag_ff !== 3'b101) begin
            n_fail++;
            $display("FAIL flag_load got %b exp 101", bus.alu_flag_ff);
        end
        bus.flag_en   = 1'b0;
        bus.alu_flags = 3'b010;
        step();
        step();
        n_cmp++;
        if (bus.alu_flag_ff !== 3'b101) begin
            n_fail++;
            $display("FAIL flag_hold got %b exp 101", bus.alu_flag_ff);
        end
    endtask

    task automatic test_clear();
        int busy_cnt = 0;
        int done_cnt = 0;
        bus.wr_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.wr_addr = 4'(i);
            bus.dat_in  = 8'h10 + 8'(i);
            step();
        end
        bus.wr_en    = 1'b0;
        bus.rd_addr0 = 4'd12;
        #1;
        n_cmp++;
        if (bus.datA_out !== 8'h1C) begin
            n_fail++;
            $display("FAIL fill_r12 got %h exp 1c", bus.datA_out);
        end
        bus.clr_req = 1'b1;
        step();
        bus.clr_req = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (bus.busy === 1'b1) busy_cnt++;
            if (bus.clr_done === 1'b1) done_cnt++;
            if (k == 5) begin
                bus.rd_addr0 = 4'd4;
                bus.rd_addr1 = 4'd5;
                #1;
                n_cmp++;
                if (bus.datA_out !== 8'h00) begin
                    n_fail++;
                    $display("FAIL live_r4 got %h exp 00", bus.datA_out);
                end
                n_cmp++;
                if (bus.datB_out !== 8'h15) begin
                    n_fail++;
                    $display("FAIL live_r5 got %h exp 15", bus.datB_out);
                end
            end
            bus.wr_en   = (k == 3);
            bus.wr_addr = 4'd2;
            bus.dat_in  = 8'hFF;
            step();
            bus.wr_en = 1'b0;
        end
        n_cmp++;
        if (busy_cnt != 17) begin
            n_fail++;
            $display("FAIL busy_cycles got %0d exp 17", busy_cnt);
        end
        n_cmp++;
        if (done_cnt != 1) begin
            n_fail++;
            $display("FAIL done_pulses got %0d exp 1", done_cnt);
        end
        for (int i = 0; i < 16; i++) begin
            bus.rd_addr0 = 4'(i);
            #1;
            n_cmp++;
            if (bus.datA_out !== 8'h00) begin
                n_fail++;
                $display("FAIL cleared_r%0d got %h exp 00", i, bus.datA_out);
            end
        end
        n_cmp++;
        if (bus.alu_flag_ff !== 3'b101) begin
            n_fail++;
            $display("FAIL flag_after_clr got %b exp 101", bus.alu_flag_ff);
        end
    endtask

    task automatic test_reset_mid_clear();
        int done_cnt = 0;
        bus.wr_en   = 1'b1;
        bus.wr_addr = 4'd1;
        bus.dat_in  = 8'h11;
        step();
        bus.wr_addr = 4'd6;
        bus.dat_in  = 8'h66;
        step();
        bus.wr_en   = 1'b0;
        bus.clr_req = 1'b1;
        step();
        bus.clr_req = 1'b0;
        for (int k = 0; k < 4; k++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        n_cmp++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_busy got %b exp 0", bus.busy);
        end
        n_cmp++;
        if (bus.clr_done !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_done got %b exp 0", bus.clr_done);
        end
        bus.rd_addr0 = 4'd6;
        bus.rd_addr1 = 4'd1;
        #1;
        n_cmp++;
        if (bus.datA_out !== 8'h00) begin
            n_fail++;
            $display("FAIL rst_mid_r6 got %h exp 00", bus.datA_out);
        end
        n_cmp++;
        if (bus.datB_out !== 8'h00) begin
            n_fail++;
            $display("FAIL rst_mid_r1 got %h exp 00", bus.datB_out);
        end
        bus.wr_en   = 1'b1;
        bus.wr_addr = 4'd1;
        bus.dat_in  = 8'h42;
        step();
        bus.wr_en = 1'b0;
        #1;
        n_cmp++;
        if (bus.datB_out !== 8'h42) begin
            n_fail++;
            $display("FAIL rst_mid_wr got %h exp 42", bus.datB_out);
        end
        for (int k = 0; k < 20; k++) begin
            if (bus.clr_done === 1'b1) done_cnt++;
            step();
        end
        n_cmp++;
        if (done_cnt != 0) begin
            n_fail++;
            $display("FAIL rst_mid_nodone got %0d exp 0", done_cnt);
        end
    endtask

    task automatic test_write_with_clear();
        bus.wr_en   = 1'b1;
        bus.wr_addr = 4'd9;
        bus.dat_in  = 8'h77;
        bus.clr_req = 1'b1;
        step();
        bus.wr_en    = 1'b0;
        bus.clr_req  = 1'b0;
        bus.rd_addr0 = 4'd9;
        #1;
        n_cmp++;
        if (bus.datA_out !== 8'h77) begin
            n_fail++;
            $display("FAIL wc_r9_now got %h exp 77", bus.datA_out);
        end
        for (int k = 0; k < 9; k++) step();
        n_cmp++;
        if (bus.datA_out !== 8'h77) begin
            n_fail++;
            $display("FAIL wc_r9_before got %h exp 77", bus.datA_out);
        end
        step();
        n_cmp++;
        if (bus.datA_out !== 8'h00) begin
            n_fail++;
            $display("FAIL wc_r9_after got %h exp 00", bus.datA_out);
        end
        for (int k = 0; k < 20 && bus.busy === 1'b1; k++) step();
        n_cmp++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL wc_busy_end got %b exp 0", bus.busy);
        end
    endtask

    initial begin
        reset         = 1'b1;
        bus.wr_en     = 1'b0;
        bus.wr_addr   = '0;
        bus.dat_in    = '0;
        bus.rd_addr0  = '0;
        bus.rd_addr1  = '0;
        bus.flag_en   = 1'b0;
        bus.alu_flags = '0;
        bus.clr_req   = 1'b0;
        test_reset();
        test_write_read();
        test_same_cycle();
        test_flags();
        test_clear();
        test_reset_mid_clear();
        test_write_with_clear();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_bank.md
# reg_bank

Parametrised successor to the 8x8 core register file: a `2**AW`-entry, `W`-bit register bank with two asynchronous read ports and one clocked write port. It also holds a separately enabled ALU flag register and a hardware bulk-clear sequencer that zeroes the array one entry per cycle. It sits between the decode stage and the ALU in the core datapath and is the only architectural state store besides the PC.

## Interface
Parameters:
- `W`, 8, data width in bits
- `AW`, 4, address width; depth `DEPTH = 2**AW`
- `FW`, 3, ALU flag width

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge
- `reset`  in  1  synchronous, active-high; sampled on the rising edge of `clk`
- `wr_en`  in  1  write request
- `wr_addr`  in  AW  write address
- `dat_in`  in  W  write data
- `rd_addr0`, `rd_addr1`  in  AW  read addresses
- `datA_out`, `datB_out`  out  W  read data (combinational)
- `flag_en`  in  1  flag register load enable
- `alu_flags`  in  FW  flag input
- `alu_flag_ff`  out  FW  registered flags
- `clr_req`  in  1  bulk-clear request
- `busy`  out  1  clear in progress; writes are refused
- `clr_done`  out  1  one-cycle pulse when a clear completes

## Operation
- Array: `DEPTH` x `W`. Reads are combinational: `datA_out = regs[rd_addr0]` and `datB_out = regs[rd_addr1]`.
- Write: a write is accepted when `wr_en && state==IDLE && !reset`. On acceptance, `regs[wr_addr] <= dat_in` at the edge.
- Flags: `alu_flag_ff <= alu_flags` when `flag_en` is high; otherwise the register holds. The flag register is independent of the clear sequencer.
- Clear FSM (`clr_state_t`): states IDLE, CLEAR, DONE.
  - IDLE: when `clr_req` is high, go to CLEAR and set `ptr <= 0`.
  - CLEAR: `regs[ptr] <= 0` and `ptr <= ptr+1`. When `ptr == DEPTH-1`, go to DONE.
  - DONE: `clr_done = 1`; return to IDLE.
- `busy = (state != IDLE)`.
- `clr_req` is ignored while `busy` is high. It is level-sampled only in IDLE.
- Writes while `busy` is high are dropped, not queued. The controller must stall on `busy`.
- Reads during CLEAR return the live array: entries below `ptr` read 0, and the rest read their old values.
- `wr_en` and `clr_req` high together in IDLE: the write commits at this edge, and CLEAR starts from the next edge. The written entry is therefore zeroed later in the sweep.
- `ptr` is `AW` bits wide and wraps naturally. The CLEAR→DONE transition uses the `ptr == DEPTH-1` compare, not the wrap.

## Timing
- Reset values: every `regs` entry is 0, `alu_flag_ff` is 0, the state is IDLE, `ptr` is 0, `busy` is 0 and `clr_done` is 0.
- Reset wins over everything in the same cycle.
- Reset mid-clear aborts to IDLE with the full array zeroed. No `clr_done` pulse is produced.
- Write-to-read latency: 1 cycle. Data is visible on the read ports in the cycle after the accepting edge.
- Flag latency: 1 cycle.
- Clear latency from the `clr_req` sample edge:
  - `busy` rises 1 cycle after that edge.
  - The sweep lasts `DEPTH` cycles in CLEAR.
  - `clr_done` is high for 1 cycle in DONE.
  - `busy` therefore stays high for `DEPTH+1` cycles.
- The earliest accepted write after a clear is in the cycle after `clr_done`.

## Configuration
- `REG_BANK_BYPASS_EN` defined: a read port returns `dat_in` in the same cycle when its address equals `wr_addr` and a write is accepted in that cycle. This is write-through forwarding, applied per port.
- `REG_BANK_BYPASS_EN` undefined: reads always return array contents, i.e. the pre-write value in the write cycle.
- Bypass never forwards dropped writes, that is, writes made while `busy` is high.

## Structure
- Package `reg_bank_pkg`:
  - `clr_state_t` enum (IDLE, CLEAR, DONE)
  - default constants `REG_W=8`, `REG_AW=4`, `REG_FW=3`
- Sub-module `reg_bank_clr_seq` holds the FSM and `ptr`. Its outputs are `busy`, `clr_done`, `clr_we` and `clr_addr`.
- The top level muxes the array write port between the external write and `clr_we`/`clr_addr`.

## Test plan
- Reset, then write 0xA5 to r3 and 0x3C to r15. Read r3 and r15 on ports A and B the next cycle → 0xA5 and 0x3C. Read any other address → 0x00.
- Same-cycle write r7=0x5A with `rd_addr0=7`:
  - bypass build → `datA_out=0x5A` in that cycle;
  - non-bypass build → old value, then 0x5A the next cycle.
- Fill all 16 entries, pulse `clr_req` → `busy` high for 17 cycles, `clr_done` pulses exactly once, and all entries then read 0x00. A `wr_en` to r2 mid-clear is dropped and r2 reads 0x00.
- `flag_en=1` with `alu_flags=3'b101`, then `flag_en=0` with `alu_flags=3'b010` → `alu_flag_ff=3'b101` holds. A clear sweep leaves the flags unchanged.
- Assert `reset` during cycle 5 of CLEAR → next cycle: `busy=0`, no `clr_done`, all entries 0, and a new write is accepted immediately.
- `wr_en` r9=0x77 together with `clr_req` in IDLE → r9 reads 0x77 one cycle later, then reads 0x00 after the sweep passes entry 9.
